// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_if
// Description : Bundle of request, MTHI/MTLO write and result signals between
//               the pipeline controller (master) and the MDU (slave).
//   start      request a new multiply/divide
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B       operands (multiplicand/dividend, multiplier/divisor)
//   hi_we      MTHI write enable
//   lo_we      MTLO write enable
//   wd         MTHI/MTLO write data
//   busy       operation in progress
//   hi, lo     HI/LO result registers
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wd;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, A, B, hi_we, lo_we, wd,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, A, B, hi_we, lo_we, wd,
        output busy, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : Iterative radix-2 multiply/divide unit with HI/LO registers.
//               Shift-add multiply and restoring divide, one bit per cycle,
//               32 cycles per operation. Signed ops work on magnitudes and
//               fix the sign when the last bit is produced.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - mdu_if.slave (start/op/A/B, hi_we/lo_we/wd, busy/hi/lo)
// Revision    : 1.0 - initial release
// ============================================================================
module mdu (
    input  wire logic clk,
    input  wire logic rst,
    mdu_if.slave      bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [5:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] a_raw;      // original dividend, returned as HI on divide by zero
    logic [31:0] mag_b;      // multiplicand / divisor magnitude
    logic [63:0] acc;        // mul: {partial, multiplier}; div: {remainder, quotient}
    logic        neg_q;      // negate product / quotient at completion
    logic        neg_r;      // negate remainder at completion
    logic        b_zero;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        done;
    logic        in_signed;
    logic [31:0] mag_a_in;
    logic [31:0] mag_b_in;
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [32:0] div_diff;
    logic [63:0] div_nxt;
    logic [63:0] acc_nxt;
    logic [63:0] prod;
    logic [31:0] hi_res;
    logic [31:0] lo_res;

    assign done      = (state == RUN) && (cnt == 6'd31);
    assign in_signed = ~bus.op[0];
    assign mag_a_in  = (in_signed && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
    assign mag_b_in  = (in_signed && bus.B[31]) ? (32'd0 - bus.B) : bus.B;

    // Multiply step: conditionally add multiplicand to the upper half,
    // then shift the whole accumulator right by one.
    assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
    assign mul_nxt = {mul_sum, acc[31:1]};

    // Restoring divide step: shift left, trial-subtract the divisor, keep the
    // difference and set the quotient bit when it did not go negative.
    // The shifted remainder only needs 33 bits because remainder < divisor.
    assign div_diff = acc[63:31] - {1'b0, mag_b};
    assign div_nxt  = div_diff[32] ? {acc[62:0], 1'b0}
                                   : {div_diff[31:0], acc[30:0], 1'b1};

    assign acc_nxt = op_q[1] ? div_nxt : mul_nxt;
    assign prod    = neg_q ? (64'd0 - acc_nxt) : acc_nxt;

    always_comb begin
        hi_res = prod[63:32];
        lo_res = prod[31:0];
        if (op_q[1]) begin
            if (b_zero) begin
                hi_res = a_raw;
                lo_res = 32'hFFFF_FFFF;
            end else begin
                hi_res = neg_r ? (32'd0 - acc_nxt[63:32]) : acc_nxt[63:32];
                lo_res = neg_q ? (32'd0 - acc_nxt[31:0])  : acc_nxt[31:0];
            end
        end
    end

    // Two-state controller
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN:  if (done)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and HI/LO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 6'd0;
            op_q   <= 2'd0;
            a_raw  <= 32'd0;
            mag_b  <= 32'd0;
            acc    <= 64'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                // start wins over a simultaneous MTHI/MTLO
                cnt    <= 6'd0;
                op_q   <= bus.op;
                a_raw  <= bus.A;
                mag_b  <= mag_b_in;
                acc    <= {32'd0, mag_a_in};
                neg_q  <= in_signed & (bus.A[31] ^ bus.B[31]);
                neg_r  <= in_signed & bus.A[31];
                b_zero <= (bus.B == 32'd0);
            end else begin
                if (bus.hi_we) hi_q <= bus.wd;
                if (bus.lo_we) lo_q <= bus.wd;
            end
        end else begin
            acc <= acc_nxt;
            cnt <= done ? 6'd0 : cnt + 6'd1;
            if (done) begin
                hi_q <= hi_res;
                lo_q <= lo_res;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu
// Description : Directed self-checking bench for mdu. Hand-computed vectors
//               for signed/unsigned multiply and divide, divide by zero,
//               signed overflow, ignored requests while busy, MTHI/MTLO
//               writes, start/write collision and reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    mdu_if bus ();

    mdu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Request an operation; returns at the falling edge after the start edge,
    // with the operand inputs scrambled to show they are not used afterwards.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic with_lo_we);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.lo_we = with_lo_we;
        bus.wd    = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    // Watch 32 cycles of RUN (busy high, hi/lo frozen), optionally injecting a
    // conflicting start + MTHI at sample inj, then check completion.
    task automatic expect_run(input string tag, input logic [31:0] exp_hi,
                              input logic [31:0] exp_lo, input int inj);
        int good;
        good = 0;
        for (int i = 0; i < 32; i++) begin
            if (bus.busy === 1'b1 && bus.hi === cur_hi && bus.lo === cur_lo) good++;
            if (i == inj) begin
                bus.start = 1'b1;
                bus.op    = 2'b00;
                bus.hi_we = 1'b1;
                bus.wd    = 32'hDEAD_BEEF;
            end else begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        chk({tag, " busy/hold cycles"}, good, 32);
        chk({tag, " busy done"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, " hi"}, bus.hi, exp_hi);
        chk({tag, " lo"}, bus.lo, exp_lo);
        cur_hi = exp_hi;
        cur_lo = exp_lo;
    endtask

    task automatic op_test(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
        issue(op, a, b, 1'b0);
        expect_run(tag, exp_hi, exp_lo, -1);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wd    = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);

        // MTHI and MTLO together
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wd    = 32'hA5A5_5A5A;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        chk("mthi", bus.hi, 32'hA5A5_5A5A);
        chk("mtlo", bus.lo, 32'hA5A5_5A5A);
        cur_hi = 32'hA5A5_5A5A;
        cur_lo = 32'hA5A5_5A5A;

        op_test("mult -2*3",       2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA);
        op_test("multu max*max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        op_test("mult maxpos*min", 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
        op_test("multu shift",     2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
        op_test("div -7/2",        2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        op_test("div 7/-2",        2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        op_test("divu 100/7",      2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
        op_test("divu 7/0",        2'b11, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF);
        op_test("div -7/0",        2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        op_test("div min/-1",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);

        // Conflicting start and MTHI in the 10th busy cycle are ignored
        issue(2'b11, 32'd1000, 32'd10, 1'b0);
        expect_run("divu busy-ignore", 32'd0, 32'd100, 9);

        // start together with MTLO: start wins, lo held until completion
        issue(2'b01, 32'd5, 32'd6, 1'b1);
        expect_run("start vs mtlo", 32'd0, 32'd30, -1);

        // Reset aborts a running MULT
        issue(2'b00, 32'd12345, 32'd678, 1'b0);
        repeat (14) @(negedge clk);
        chk("abort pre busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort hi", bus.hi, 32'd0);
        chk("abort lo", bus.lo, 32'd0);
        bus.lo_we = 1'b1;
        bus.wd    = 32'h0000_1234;
        @(negedge clk);
        bus.lo_we = 1'b0;
        chk("mtlo after abort lo", bus.lo, 32'h0000_1234);
        chk("mtlo after abort hi", bus.hi, 32'd0);
        // Aborted operation must not complete later
        repeat (40) @(negedge clk);
        chk("abort no late write", bus.lo, 32'h0000_1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
